// File: rtl/avalon_mem_responder.sv
// Avalon-MM word RAM responder: byte-enable writes, fixed-latency in-order reads, SLAVEERROR
// with DEADBEEF data for out-of-range words. Macro AVS_MEM_RAND_STALL_EN adds LFSR waitrequest stalls.
module avalon_mem_responder #(
  parameter int MemWords       = 4096,
  parameter int ReadLatency    = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] avs_address,
  input  logic [3:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [1:0]  avs_response
);
  localparam int AW = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [1:0]    RespOkay   = 2'b00;
  localparam logic [1:0]    RespSlvErr = 2'b10;
  localparam logic [CW-1:0] OutMax     = CW'(MaxOutstanding);

  logic [31:0]            r_mem [MemWords];
  logic [ReadLatency-1:0] r_pipe_vld;
  logic [31:0]            r_pipe_dat [ReadLatency];
  logic [1:0]             r_pipe_rsp [ReadLatency];
  logic [CW-1:0]          r_outstanding;

  logic          w_stall;
  logic          w_cmd_acc;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_in_range;
  logic          w_retire;
  logic [AW-1:0] w_word;
  logic [31:0]   w_rd_dat;
  logic [1:0]    w_rd_rsp;

`ifdef AVS_MEM_RAND_STALL_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // Depends only on registered state (and reset), never on the current command.
  assign avs_waitrequest = rst_i || (r_outstanding == OutMax) || w_stall;

  assign w_cmd_acc  = (avs_read || avs_write) && !avs_waitrequest;
  assign w_wr_acc   = w_cmd_acc && avs_write;
  assign w_rd_acc   = w_cmd_acc && avs_read && !avs_write;
  assign w_in_range = (avs_address < 32'(MemWords));
  assign w_word     = avs_address[AW-1:0];
  assign w_rd_dat   = w_in_range ? r_mem[w_word] : 32'hDEADBEEF;
  assign w_rd_rsp   = w_in_range ? RespOkay : RespSlvErr;
  assign w_retire   = r_pipe_vld[ReadLatency-1];

  always_ff @(posedge clk_i) begin
    if (w_wr_acc && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (avs_byteenable[i]) begin
          r_mem[w_word][8*i +: 8] <= avs_writedata[8*i +: 8];
        end
      end
    end
  end

  // Idle stages carry zero data so the outputs are zero whenever not valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < ReadLatency; i++) begin
        r_pipe_dat[i] <= '0;
        r_pipe_rsp[i] <= RespOkay;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_acc;
      r_pipe_dat[0] <= w_rd_acc ? w_rd_dat : 32'h0;
      r_pipe_rsp[0] <= w_rd_acc ? w_rd_rsp : RespOkay;
      for (int i = 1; i < ReadLatency; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_dat[i] <= r_pipe_dat[i-1];
        r_pipe_rsp[i] <= r_pipe_rsp[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else if (w_rd_acc && !w_retire) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_rd_acc && w_retire) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  assign avs_readdatavalid = r_pipe_vld[ReadLatency-1];
  assign avs_readdata      = r_pipe_dat[ReadLatency-1];
  assign avs_response      = r_pipe_rsp[ReadLatency-1];

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: default instance plus a MaxOutstanding=1,
// ReadLatency=3 instance for back-pressure; random model check at the end.
module tb_avalon_mem_responder;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] avs_address;
  logic [3:0]  avs_byteenable;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [1:0]  avs_response;

  logic [31:0] d2_address;
  logic [3:0]  d2_byteenable;
  logic        d2_read;
  logic        d2_write;
  logic [31:0] d2_writedata;
  logic        d2_waitrequest;
  logic [31:0] d2_readdata;
  logic        d2_readdatavalid;
  logic [1:0]  d2_response;

  int n_checks = 0;
  int n_pass = 0;
  int bus_timeouts = 0;
  int wait_seen = 0;

  always #5 clk_i = ~clk_i;

  avalon_mem_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .avs_address(avs_address), .avs_byteenable(avs_byteenable),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_response(avs_response)
  );

  avalon_mem_responder #(.MemWords(4096), .ReadLatency(3), .MaxOutstanding(1)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i),
    .avs_address(d2_address), .avs_byteenable(d2_byteenable),
    .avs_read(d2_read), .avs_write(d2_write), .avs_writedata(d2_writedata),
    .avs_waitrequest(d2_waitrequest), .avs_readdata(d2_readdata),
    .avs_readdatavalid(d2_readdatavalid), .avs_response(d2_response)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hold the command until a cycle with waitrequest low; returns just after the accepting edge.
  task automatic wait_accept(output bit ok);
    int guard;
    guard = 0;
    @(negedge clk_i);
    while (avs_waitrequest && guard < 64) begin
      wait_seen++;
      guard++;
      @(negedge clk_i);
    end
    ok = !avs_waitrequest;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bit ok;
    avs_address = addr;
    avs_writedata = data;
    avs_byteenable = be;
    avs_write = 1'b1;
    wait_accept(ok);
    avs_write = 1'b0;
    if (!ok) bus_timeouts++;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] rsp, output int lat);
    bit ok;
    avs_address = addr;
    avs_read = 1'b1;
    wait_accept(ok);
    avs_read = 1'b0;
    data = 32'h0;
    rsp = 2'b00;
    lat = -1;
    if (!ok) begin
      bus_timeouts++;
    end else begin
      lat = 0;
      do begin
        @(negedge clk_i);
        lat++;
      end while (!avs_readdatavalid && lat < 16);
      data = avs_readdata;
      rsp = avs_response;
      if (!avs_readdatavalid) lat = -1;
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (avs_waitrequest !== 1'b1) $display("FAIL reset_wait: got %b want 1", avs_waitrequest); else n_pass++;
    n_checks++;
    if (avs_readdatavalid !== 1'b0) $display("FAIL reset_rvld: got %b want 0", avs_readdatavalid); else n_pass++;
    n_checks++;
    if ({avs_response, avs_readdata} !== 34'h0) $display("FAIL reset_rdata: got %h/%h want 0/0", avs_response, avs_readdata); else n_pass++;
    n_checks++;
    if (d2_waitrequest !== 1'b1) $display("FAIL reset_wait2: got %b want 1", d2_waitrequest); else n_pass++;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (avs_waitrequest !== 1'b0) $display("FAIL post_reset_wait: got %b want 0", avs_waitrequest); else n_pass++;
    n_checks++;
    if (d2_waitrequest !== 1'b0) $display("FAIL post_reset_wait2: got %b want 0", d2_waitrequest); else n_pass++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_write_read;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    do_write(32'd5, 32'h11223344, 4'b1111);
    do_read(32'd5, d, r, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL wr_rd_latency: got %0d want 2", lat); else n_pass++;
    n_checks++;
    if (d !== 32'h11223344) $display("FAIL wr_rd_data: got %h want 11223344", d); else n_pass++;
    n_checks++;
    if (r !== 2'b00) $display("FAIL wr_rd_resp: got %b want 00", r); else n_pass++;
  endtask

  task automatic test_byteenable;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    do_write(32'd5, 32'hAABBCCDD, 4'b0101);
    do_read(32'd5, d, r, lat);
    n_checks++;
    if (d !== 32'h11BB33DD) $display("FAIL be_0101: got %h want 11BB33DD", d); else n_pass++;
    do_write(32'd5, 32'hFFFFFFFF, 4'b0000);
    do_read(32'd5, d, r, lat);
    n_checks++;
    if (d !== 32'h11BB33DD) $display("FAIL be_0000: got %h want 11BB33DD", d); else n_pass++;
    do_write(32'd5, 32'h00FF_FFFF, 4'b1000);
    do_read(32'd5, d, r, lat);
    n_checks++;
    if (d !== 32'h00BB33DD) $display("FAIL be_1000: got %h want 00BB33DD", d); else n_pass++;
  endtask

  task automatic test_out_of_range;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    do_write(32'd0, 32'h12345678, 4'b1111);
    do_write(32'd4096, 32'hCAFEF00D, 4'b1111);
    do_read(32'd4096, d, r, lat);
    n_checks++;
    if (d !== 32'hDEADBEEF) $display("FAIL oor_data: got %h want DEADBEEF", d); else n_pass++;
    n_checks++;
    if (r !== 2'b10) $display("FAIL oor_resp: got %b want 10", r); else n_pass++;
    n_checks++;
    if (lat !== 2) $display("FAIL oor_latency: got %0d want 2", lat); else n_pass++;
    do_read(32'd0, d, r, lat);
    n_checks++;
    if ({r, d} !== {2'b00, 32'h12345678}) $display("FAIL oor_no_alias: got %b/%h want 00/12345678", r, d); else n_pass++;
    do_read(32'hFFFF_FFFF, d, r, lat);
    n_checks++;
    if ({r, d} !== {2'b10, 32'hDEADBEEF}) $display("FAIL oor_top: got %b/%h want 10/DEADBEEF", r, d); else n_pass++;
  endtask

  task automatic test_rw_conflict;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          pulses;
    bit          ok;
    do_write(32'd7, 32'h01010101, 4'b1111);
    avs_address = 32'd7;
    avs_writedata = 32'h77777777;
    avs_byteenable = 4'b1111;
    avs_read = 1'b1;
    avs_write = 1'b1;
    wait_accept(ok);
    avs_read = 1'b0;
    avs_write = 1'b0;
    if (!ok) bus_timeouts++;
    pulses = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (avs_readdatavalid) pulses++;
    end
    @(posedge clk_i);
    #1;
    n_checks++;
    if (pulses !== 0) $display("FAIL rw_no_response: got %0d pulses want 0", pulses); else n_pass++;
    do_read(32'd7, d, r, lat);
    n_checks++;
    if (d !== 32'h77777777) $display("FAIL rw_write_wins: got %h want 77777777", d); else n_pass++;
    n_checks++;
    if (lat !== 2) $display("FAIL rw_latency: got %0d want 2", lat); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [4];
    int acc, got, cyc, first_v, last_v;
    bit acc_now;
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = 32'hB0B0_0000 + 32'(i * 17);
      do_write(32'(10 + i), exp_d[i], 4'b1111);
    end
    avs_address = 32'd10;
    avs_read = 1'b1;
    acc = 0; got = 0; cyc = 0; first_v = -1; last_v = -1;
    while (got < 4 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
      if (avs_readdatavalid) begin
        n_checks++;
        if (avs_readdata !== exp_d[got]) $display("FAIL b2b_data%0d: got %h want %h", got, avs_readdata, exp_d[got]); else n_pass++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        got++;
      end
      acc_now = avs_read && !avs_waitrequest;
      if (avs_read && avs_waitrequest) wait_seen++;
      @(posedge clk_i);
      #1;
      if (acc_now) begin
        acc++;
        if (acc == 4) avs_read = 1'b0;
        else avs_address = 32'(10 + acc);
      end
    end
    avs_read = 1'b0;
    n_checks++;
    if (got !== 4) $display("FAIL b2b_count: got %0d want 4", got); else n_pass++;
`ifndef AVS_MEM_RAND_STALL_EN
    n_checks++;
    if (first_v !== 3) $display("FAIL b2b_first_cycle: got %0d want 3", first_v); else n_pass++;
    n_checks++;
    if (last_v - first_v !== 3) $display("FAIL b2b_contiguous: got span %0d want 3", last_v - first_v); else n_pass++;
`endif
  endtask

  task automatic test_max_outstanding;
    int acc, got, cyc, waits, max_out, g;
    int acc_cyc [4];
    bit acc_now;
    for (int i = 0; i < 4; i++) begin
      d2_address = 32'(i);
      d2_writedata = 32'hD200_0000 + 32'(i);
      d2_byteenable = 4'b1111;
      d2_write = 1'b1;
      g = 0;
      @(negedge clk_i);
      while (d2_waitrequest && g < 64) begin
        g++;
        @(negedge clk_i);
      end
      if (d2_waitrequest) bus_timeouts++;
      @(posedge clk_i);
      #1;
      d2_write = 1'b0;
    end
    d2_address = 32'd0;
    d2_read = 1'b1;
    acc = 0; got = 0; cyc = 0; waits = 0; max_out = 0;
    while (got < 4 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (acc - got > max_out) max_out = acc - got;
      if (d2_readdatavalid) begin
        n_checks++;
        if ({d2_response, d2_readdata} !== {2'b00, 32'hD200_0000 + 32'(got)})
          $display("FAIL mo_data%0d: got %b/%h want 00/%h", got, d2_response, d2_readdata, 32'hD200_0000 + 32'(got));
        else n_pass++;
        n_checks++;
        if (got < acc && cyc - acc_cyc[got] !== 3)
          $display("FAIL mo_latency%0d: got %0d want 3", got, cyc - acc_cyc[got]);
        else if (got >= acc) $display("FAIL mo_unrequested%0d: got pulse want none", got);
        else n_pass++;
        got++;
      end
      if (d2_read && d2_waitrequest) waits++;
      acc_now = d2_read && !d2_waitrequest;
      @(posedge clk_i);
      #1;
      if (acc_now) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc == 4) d2_read = 1'b0;
        else d2_address = 32'(acc);
      end
    end
    d2_read = 1'b0;
    n_checks++;
    if (got !== 4) $display("FAIL mo_count: got %0d want 4", got); else n_pass++;
    n_checks++;
    if (max_out > 1) $display("FAIL mo_max_outstanding: got %0d want <=1", max_out); else n_pass++;
`ifndef AVS_MEM_RAND_STALL_EN
    n_checks++;
    if (waits !== 9) $display("FAIL mo_wait_cycles: got %0d want 9", waits); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          pulses;
    bit          ok;
    do_write(32'd20, 32'h55AA55AA, 4'b1111);
    do_write(32'd21, 32'h66BB66BB, 4'b1111);
    avs_address = 32'd20;
    avs_read = 1'b1;
    wait_accept(ok);
    if (!ok) bus_timeouts++;
    avs_address = 32'd21;
    wait_accept(ok);
    if (!ok) bus_timeouts++;
    rst_i = 1'b1;
    avs_read = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({avs_waitrequest, avs_readdatavalid, avs_response, avs_readdata} !== {1'b1, 1'b0, 2'b00, 32'h0})
      $display("FAIL midrst_outputs: got wr=%b v=%b r=%b d=%h want 1/0/00/0",
               avs_waitrequest, avs_readdatavalid, avs_response, avs_readdata);
    else n_pass++;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (avs_readdatavalid) pulses++;
    end
    @(posedge clk_i);
    #1;
    n_checks++;
    if (pulses !== 0) $display("FAIL midrst_discard: got %0d pulses want 0", pulses); else n_pass++;
    do_read(32'd20, d, r, lat);
    n_checks++;
    if ({r, d} !== {2'b00, 32'h55AA55AA}) $display("FAIL midrst_keep20: got %b/%h want 00/55AA55AA", r, d); else n_pass++;
    do_read(32'd21, d, r, lat);
    n_checks++;
    if (d !== 32'h66BB66BB) $display("FAIL midrst_keep21: got %h want 66BB66BB", d); else n_pass++;
    n_checks++;
    if (lat !== 2) $display("FAIL midrst_latency: got %0d want 2", lat); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] model [16];
    logic [31:0] d, wd, exp_d, a;
    logic [1:0]  r, exp_r;
    logic [3:0]  be;
    int          lat, sel;
    wait_seen = 0;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      do_write(32'(100 + i), model[i], 4'b1111);
    end
    for (int n = 0; n < 100; n++) begin
      sel = $urandom_range(0, 19);
      a = (sel < 16) ? 32'(100 + sel) : 32'(4096 + sel);
      if ($urandom_range(0, 1) == 0) begin
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
        do_write(a, wd, be);
        if (sel < 16) begin
          for (int b = 0; b < 4; b++) if (be[b]) model[sel][8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        do_read(a, d, r, lat);
        exp_d = (sel < 16) ? model[sel] : 32'hDEADBEEF;
        exp_r = (sel < 16) ? 2'b00 : 2'b10;
        n_checks++;
        if ({r, d} !== {exp_r, exp_d} || lat !== 2)
          $display("FAIL rand_read%0d addr %0d: got %b/%h lat %0d want %b/%h lat 2", n, a, r, d, lat, exp_r, exp_d);
        else n_pass++;
      end
    end
`ifdef AVS_MEM_RAND_STALL_EN
    n_checks++;
    if (wait_seen < 20) $display("FAIL rand_stalls: got %0d want >=20", wait_seen); else n_pass++;
`endif
  endtask

  initial begin
    rst_i = 1'b1;
    avs_address = '0; avs_byteenable = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    d2_address = '0; d2_byteenable = '0; d2_read = 1'b0; d2_write = 1'b0; d2_writedata = '0;
    test_reset();
    test_write_read();
    test_byteenable();
    test_out_of_range();
    test_rw_conflict();
    test_back_to_back();
    test_max_outstanding();
    test_reset_mid();
    test_random();
    n_checks++;
    if (bus_timeouts !== 0) $display("FAIL handshake_timeouts: got %0d want 0", bus_timeouts); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/avalon_mem_responder.md
Name: avalon_mem_responder

Overview:
- Avalon-MM responder (slave) that answers the data-side master port of the core wrapper: word-addressed RAM with byte-enable writes.
- Reads are pipelined with fixed latency, plus waitrequest back-pressure and SLAVEERROR responses for out-of-range addresses.
- Used as on-chip main memory in simulation and FPGA builds, attached directly to the wrapper's avm_main_* port.

Parameters:
- MemWords, 4096: number of 32-bit words; valid word addresses are 0..MemWords-1.
- ReadLatency, 2: cycles from read acceptance to readdatavalid. Legal range 1..4.
- MaxOutstanding, 4: maximum reads in flight before waitrequest asserts. Legal range 1..8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- avs_address  in  32  word address
- avs_byteenable  in  4  write byte lanes
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  32  write data
- avs_waitrequest  out  1  command not accepted this cycle
- avs_readdata  out  32  read data
- avs_readdatavalid  out  1  readdata/response valid
- avs_response  out  2  00 OKAY, 10 SLAVEERROR

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - avs_waitrequest=1 while rst_i is high, and 0 from the first cycle after deassertion.
  - avs_readdatavalid=0, avs_readdata=0, avs_response=00.
  - Outstanding counter=0; all read pipeline stages invalid.
  - Memory array is not reset.
- Acceptance: a command is accepted in a cycle where (avs_read|avs_write)=1, avs_waitrequest=0 and rst_i=0. The master holds the command while waitrequest=1.
- avs_waitrequest is a function of registered state only (never of the current command):
  - 1 when outstanding==MaxOutstanding;
  - else 0 (see optional feature).
- Write:
  - On acceptance with address<MemWords, each byte lane i with avs_byteenable[i]=1 is updated at the clock edge.
  - byteenable=0000 is accepted with no change.
  - Writes produce no response.
- Out-of-range write (address>=MemWords): accepted and dropped; memory unchanged; no response.
- Read:
  - Memory is sampled at the acceptance edge and carried through a ReadLatency-deep valid/data/response shift pipeline.
  - avs_readdatavalid pulses exactly ReadLatency cycles after acceptance, one cycle per read, strictly in order.
  - Back-to-back reads give back-to-back readdatavalid.
- Out-of-range read: readdata=32'hDEADBEEF, response=10.
- avs_readdata and avs_response are 0 whenever avs_readdatavalid=0.
- Simultaneous avs_read and avs_write: the write wins, the read is ignored, and no readdatavalid is produced for it.
- Read after write to the same word in the next cycle returns the new data; there is no hazard window.
- Outstanding counter:
  - +1 on read acceptance, -1 on readdatavalid; both in the same cycle leave it unchanged.
  - Width is clog2(MaxOutstanding+1).
  - Never exceeds MaxOutstanding.
  - A retire in the same cycle does not release waitrequest until the next cycle.
- Reset mid-operation: all in-flight reads are discarded without readdatavalid; writes already clocked remain in memory.

Optional Feature:
- Macro: AVS_MEM_RAND_STALL_EN.
- Enabled:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle out of reset.
  - avs_waitrequest is additionally asserted when lfsr[1:0]==00, to stress master back-pressure handling.
  - Read latency counts from the actual acceptance cycle.
- Disabled: no LFSR logic exists; waitrequest depends on occupancy only.

Test Plan:
- Reset then write addr 5, data 32'h11223344, be 1111; read addr 5 -> readdatavalid exactly 2 cycles after acceptance, readdata 32'h11223344, response 00.
- Write addr 5, data 32'hAABBCCDD, be 0101; read addr 5 -> readdata 32'h11BB33DD.
- Write 32'hCAFEF00D to addr 4096 (MemWords=4096); read addr 4096 -> readdata 32'hDEADBEEF, response 10; prior read of addr 0 is unchanged.
- MaxOutstanding=1, ReadLatency=3, read held high for reads of addr 0..3 -> waitrequest high 3 of every 4 cycles; four in-order readdatavalid pulses; the counter never exceeds 1.
- Assert rst_i one cycle after 2 reads are accepted -> no readdatavalid pulses; all outputs at reset values; previously written data is intact on a later read.
- AVS_MEM_RAND_STALL_EN defined, 100 random reads/writes checked against a reference model -> all data matches and waitrequest is observed at least 20 times.
